l1_l2_miss_sequencer: RTL
=========================

Name: l1_l2_miss_sequencer

Overview:
- Shares the single L2 request port between the 4-way instruction cache (read-only misses) and the 8-way data cache (read, read-for-ownership, dirty-victim writeback).
- Arbitrates 2 requesters round-robin, serializes one miss at a time, and orders a dirty writeback before its fill.
- Returns the MESI install state for the filled line.
- Sits between the L1 cache lookup/LRU logic and the L2 bus interface.

Parameters:
ADDR_W, 32, address width
OFFSET_W, 6, line offset bits (64-byte line); low OFFSET_W bits forced 0 on L2 address

Ports:
clk  in  1  clock
rst  in  1  reset
i_req_valid  in  1  I-cache miss request
i_req_ready  out  1  I-cache request accepted this cycle when high with valid
i_req_addr  in  ADDR_W  I-cache miss address
d_req_valid  in  1  D-cache miss request
d_req_ready  out  1  D-cache request accepted when high with valid
d_req_addr  in  ADDR_W  D-cache miss address
d_req_rfo  in  1  1 = write miss (read-for-ownership), 0 = read miss
d_wb_valid  in  1  victim is M; writeback required (sampled with d_req)
d_wb_addr  in  ADDR_W  victim line address
i_done  out  1  one-cycle pulse: I fill complete
d_done  out  1  one-cycle pulse: D fill complete
fill_state  out  2  mesi_state_t to install, valid with i_done/d_done
l2_req_valid  out  1  L2 command valid
l2_req_ready  in  1  L2 accepts command
l2_cmd  out  2  l2_cmd_t: READ, RFO, WRITEBACK
l2_addr  out  ADDR_W  line-aligned L2 address
l2_resp_valid  in  1  L2 completion for outstanding command
l2_resp_shared  in  1  another cache holds line (fills only)
busy  out  1  high in any state other than IDLE

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, rr pointer = D-last (I-cache wins first tie), fill_state = I.
- States: IDLE, WB_ISSUE, WB_WAIT, FILL_ISSUE, FILL_WAIT, DONE.
- IDLE ready logic: combinational; only one of i_req_ready/d_req_ready is high.
  - Single valid requester gets ready.
  - Both valid: requester not granted last gets ready.
  - Ready is 0 in every other state.
- Acceptance at cycle N: latch addr, rfo, wb, and source; update rr pointer.
  - D with d_wb_valid -> WB_ISSUE.
  - Otherwise -> FILL_ISSUE.
  - l2_req_valid is high at N+1.
- *_ISSUE states: hold l2_req_valid, l2_cmd, and l2_addr stable until l2_req_ready. Leave for *_WAIT the cycle after the handshake; l2_req_valid drops in that cycle.
- WB_WAIT: on l2_resp_valid -> FILL_ISSUE; l2_resp_shared is ignored.
- l2_cmd values:
  - I requests: READ.
  - D requests: RFO if rfo, else READ.
  - Writebacks: WRITEBACK with d_wb_addr.
- FILL_WAIT: on l2_resp_valid, register fill_state -> DONE.
  - RFO: M.
  - READ with shared=1: S.
  - READ with shared=0: E.
- DONE: exactly one of i_done/d_done high for one cycle, fill_state valid; next state IDLE.
- Back-to-back: a new request may be accepted the cycle after DONE; minimum I-miss turnaround is 4 cycles with zero L2 latency.
- l2_resp_valid outside *_WAIT states is ignored. l2_resp_valid in the same cycle as the issue handshake is not allowed; it is ignored.
- rst mid-operation: next cycle IDLE, l2_req_valid=0, no done pulse, outstanding request dropped.
- Requester dropping valid before ready is legal; no state change.

Optional Feature:
- ARB_STATS_EN defined: adds outputs i_grant_cnt, d_grant_cnt, wb_cnt (each 32 bits).
  - Each counter increments on I acceptance, D acceptance, and writeback completion respectively.
  - Counters wrap at 2^32 and are cleared by rst.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- pkg_cache adds:
  - typedef enum l2_cmd_t {READ=2'b00, RFO=2'b01, WRITEBACK=2'b10}
  - typedef enum seq_state_t (6 states)
  - localparam LINE_OFFSET_W=6
- Reuses mesi_state_t.
- One sub-module: rr_arb2, a 2-input round-robin arbiter with a pointer register updated on grant acceptance.

Test Plan:
- I read, L2 ready immediately, resp 3 cycles later with shared=0, addr 0x1234_5678 -> l2_cmd=READ, l2_addr=0x1234_5640, i_done pulse, fill_state=E.
- D write miss with dirty victim (addr 0x0000_1000, victim 0x0ABC_0040) -> WRITEBACK to 0x0ABC_0040, then after resp RFO to 0x0000_1000; d_done with fill_state=M; no done after writeback.
- I and D valid simultaneously 3 times, each serviced -> grants I, D, I; ready never both high.
- D read, l2_req_ready held low 5 cycles -> l2_cmd/addr stable all 5 cycles; resp shared=1 -> fill_state=S.
- rst asserted in FILL_WAIT -> next cycle busy=0, l2_req_valid=0, no d_done; a later stray l2_resp_valid is ignored.
- ARB_STATS_EN build running the above sequence -> counters match grant and writeback totals; non-macro build compiles without the stats ports.

Source files
------------

// File: rtl/l1_l2_miss_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// l1_l2_miss_sequencer_pkg
// Shared types for the L1 -> L2 miss sequencer: L2 command encoding, MESI
// install state, sequencer FSM states and the cache line offset width.
// ---------------------------------------------------------------------------
package l1_l2_miss_sequencer_pkg;

    localparam int LINE_OFFSET_W = 6;

    typedef enum logic [1:0] {
        MESI_I = 2'b00,
        MESI_S = 2'b01,
        MESI_E = 2'b10,
        MESI_M = 2'b11
    } mesi_state_t;

    typedef enum logic [1:0] {
        READ      = 2'b00,
        RFO       = 2'b01,
        WRITEBACK = 2'b10
    } l2_cmd_t;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WB_ISSUE   = 3'd1,
        WB_WAIT    = 3'd2,
        FILL_ISSUE = 3'd3,
        FILL_WAIT  = 3'd4,
        DONE       = 3'd5
    } seq_state_t;

endpackage

// File: rtl/l1_l2_miss_sequencer_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin arbiter (I-cache vs D-cache). Grants are
// combinational and only offered while en is high; the pointer remembers
// which side was granted last and moves on every grant.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            arbitration window open (sequencer idle)
//   req_i, req_d  request valids
//   gnt_i, gnt_d  one-hot grant (doubles as the ready to each requester)
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_i,
    input  logic req_d,
    output logic gnt_i,
    output logic gnt_d
);

    // 1 = D was granted last, so I wins the next tie
    logic last_d;

    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (en) begin
            if (req_i && req_d) begin
                gnt_i = last_d;
                gnt_d = !last_d;
            end else begin
                gnt_i = req_i;
                gnt_d = req_d;
            end
        end
    end

    // A grant is only ever raised alongside its valid, so a grant is an
    // accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_d <= 1'b1;
        end else if (gnt_i) begin
            last_d <= 1'b0;
        end else if (gnt_d) begin
            last_d <= 1'b1;
        end
    end

endmodule

// File: rtl/l1_l2_miss_sequencer.sv
// ---------------------------------------------------------------------------
// l1_l2_miss_sequencer
// Shares one L2 request port between the I-cache (read misses) and the
// D-cache (read / read-for-ownership misses with optional dirty-victim
// writeback). One miss in flight at a time; a dirty victim is written back
// before its fill is requested. Returns the MESI state to install.
//
// Optional build macro: ARB_STATS_EN adds i_grant_cnt, d_grant_cnt, wb_cnt.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_req_valid/ready/addr        I-cache miss request
//   d_req_valid/ready/addr/rfo    D-cache miss request
//   d_wb_valid, d_wb_addr         dirty victim to write back first
//   i_done, d_done                one-cycle fill-complete pulses
//   fill_state                    mesi_state_t to install, valid with done
//   l2_req_valid/ready            L2 command handshake
//   l2_cmd, l2_addr               L2 command and line-aligned address
//   l2_resp_valid, l2_resp_shared L2 completion and shared indication
//   busy                          sequencer not idle
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for a miss; arbiter offers ready
// WB_ISSUE   | WRITEBACK command presented to L2
// WB_WAIT    | waiting for writeback completion
// FILL_ISSUE | READ/RFO command presented to L2
// FILL_WAIT  | waiting for fill completion; captures install state
// DONE       | done pulse to the owning cache
// ---------------------------------------------------------------------------
module l1_l2_miss_sequencer
    import l1_l2_miss_sequencer_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = LINE_OFFSET_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic              d_req_rfo,
    input  logic              d_wb_valid,
    input  logic [ADDR_W-1:0] d_wb_addr,
    output logic              i_done,
    output logic              d_done,
    output logic [1:0]        fill_state,
    output logic              l2_req_valid,
    input  logic              l2_req_ready,
    output logic [1:0]        l2_cmd,
    output logic [ADDR_W-1:0] l2_addr,
    input  logic              l2_resp_valid,
    input  logic              l2_resp_shared,
`ifdef ARB_STATS_EN
    output logic [31:0]       i_grant_cnt,
    output logic [31:0]       d_grant_cnt,
    output logic [31:0]       wb_cnt,
`endif
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LINE_MASK =
        {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    seq_state_t  state, state_nxt;
    mesi_state_t fill_q, fill_nxt;
    l2_cmd_t     cmd;

    logic [ADDR_W-1:0] req_addr_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic              src_d_q;
    logic              rfo_q;

    logic gnt_i, gnt_d;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (state == IDLE),
        .req_i (i_req_valid),
        .req_d (d_req_valid),
        .gnt_i (gnt_i),
        .gnt_d (gnt_d)
    );

    assign i_req_ready = gnt_i;
    assign d_req_ready = gnt_d;
    assign busy        = (state != IDLE);
    assign fill_state  = fill_q;
    assign l2_cmd      = cmd;

    always_comb begin
        state_nxt    = state;
        fill_nxt     = fill_q;
        l2_req_valid = 1'b0;
        cmd          = READ;
        l2_addr      = '0;
        i_done       = 1'b0;
        d_done       = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_d && d_wb_valid) begin
                    state_nxt = WB_ISSUE;
                end else if (gnt_i || gnt_d) begin
                    state_nxt = FILL_ISSUE;
                end
            end
            WB_ISSUE: begin
                l2_req_valid = 1'b1;
                cmd          = WRITEBACK;
                l2_addr      = wb_addr_q & LINE_MASK;
                if (l2_req_ready) begin
                    state_nxt = WB_WAIT;
                end
            end
            WB_WAIT: begin
                if (l2_resp_valid) begin
                    state_nxt = FILL_ISSUE;
                end
            end
            FILL_ISSUE: begin
                l2_req_valid = 1'b1;
                cmd          = (src_d_q && rfo_q) ? RFO : READ;
                l2_addr      = req_addr_q & LINE_MASK;
                if (l2_req_ready) begin
                    state_nxt = FILL_WAIT;
                end
            end
            FILL_WAIT: begin
                if (l2_resp_valid) begin
                    if (src_d_q && rfo_q) begin
                        fill_nxt = MESI_M;
                    end else if (l2_resp_shared) begin
                        fill_nxt = MESI_S;
                    end else begin
                        fill_nxt = MESI_E;
                    end
                    state_nxt = DONE;
                end
            end
            DONE: begin
                i_done    = !src_d_q;
                d_done    = src_d_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q     <= MESI_I;
            req_addr_q <= '0;
            wb_addr_q  <= '0;
            src_d_q    <= 1'b0;
            rfo_q      <= 1'b0;
        end else begin
            fill_q <= fill_nxt;
            if (gnt_i) begin
                req_addr_q <= i_req_addr;
                src_d_q    <= 1'b0;
                rfo_q      <= 1'b0;
            end else if (gnt_d) begin
                req_addr_q <= d_req_addr;
                wb_addr_q  <= d_wb_addr;
                src_d_q    <= 1'b1;
                rfo_q      <= d_req_rfo;
            end
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            i_grant_cnt <= '0;
            d_grant_cnt <= '0;
            wb_cnt      <= '0;
        end else begin
            if (gnt_i) begin
                i_grant_cnt <= i_grant_cnt + 32'd1;
            end
            if (gnt_d) begin
                d_grant_cnt <= d_grant_cnt + 32'd1;
            end
            if (state == WB_WAIT && l2_resp_valid) begin
                wb_cnt <= wb_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
